// File: rtl/gsensor_spi.sv
// ADXL345-style SPI master: runs the four-write configuration sequence after reset,
// then issues 56-bit burst reads of X/Y/Z on trigger or int1 (SPI mode 3, MSB first).
module gsensor_spi #(
  parameter int CLK_DIV = 25,
  parameter int GAP     = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trigger,
  input  logic        int1,
  input  logic        gsensor_sdo,
  output logic        gsensor_sclk,
  output logic        gsensor_cs_,
  output logic        gsensor_sdi,
  output logic        init_done,
  output logic        busy,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic [15:0] z,
  output logic        sample_valid
);

  typedef enum logic [2:0] {INIT_FMT, INIT_MAP, INIT_EN, INIT_PWR, IDLE, READ} state_t;
  typedef enum logic [2:0] {P_IDLE, P_LEAD, P_LOW, P_HIGH, P_TAIL, P_GAP} phase_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP - 1);
  localparam logic [5:0] WR_BITS  = 6'd16;
  localparam logic [5:0] RD_BITS  = 6'd56;
  localparam logic [7:0] RD_HDR   = 8'hF2;

  state_t      state, state_nx;
  phase_t      phase, phase_nx;
  logic [7:0]  div_cnt;
  logic [5:0]  bit_cnt, nbits;
  logic [55:0] tx_sr;
  logic [47:0] rx_sr;
  logic [15:0] wr_word;
  logic        int1_m, int1_s, pending, armed, rd_frame;
  logic        div_tick, last_bit, shift_out, frame_done, is_init, req, go;

  assign is_init    = (state != IDLE) && (state != READ);
  assign req        = trigger | int1_s | pending;
  // armed delays the first init frame by one cycle after reset release
  assign go         = (is_init && armed && phase == P_IDLE) || (state == IDLE && req);
  assign div_tick   = (div_cnt == ((phase == P_GAP) ? GAP_LAST : DIV_LAST));
  assign frame_done = (phase == P_GAP) && div_tick;
  assign last_bit   = (bit_cnt == nbits);
  assign shift_out  = div_tick && (phase == P_LEAD || (phase == P_HIGH && !last_bit));
  assign init_done  = !is_init;
  assign busy       = (phase != P_IDLE) || (is_init && armed);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT_FMT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    wr_word  = 16'h0000;
    case (state)
      INIT_FMT: begin wr_word = {2'b00, 6'h31, 8'h0B}; if (frame_done) state_nx = INIT_MAP; end
      INIT_MAP: begin wr_word = {2'b00, 6'h2F, 8'h00}; if (frame_done) state_nx = INIT_EN;  end
      INIT_EN:  begin wr_word = {2'b00, 6'h2E, 8'h80}; if (frame_done) state_nx = INIT_PWR; end
      INIT_PWR: begin wr_word = {2'b00, 6'h2D, 8'h08}; if (frame_done) state_nx = IDLE;     end
      IDLE:     if (req) state_nx = READ;
      READ:     if (frame_done) state_nx = IDLE;
      default:  state_nx = INIT_FMT;
    endcase
  end

  always_comb begin
    phase_nx = phase;
    case (phase)
      P_IDLE:  if (go) phase_nx = P_LEAD;
      P_LEAD:  if (div_tick) phase_nx = P_LOW;
      P_LOW:   if (div_tick) phase_nx = P_HIGH;
      P_HIGH:  if (div_tick) phase_nx = last_bit ? P_TAIL : P_LOW;
      P_TAIL:  if (div_tick) phase_nx = P_GAP;
      P_GAP:   if (div_tick) phase_nx = P_IDLE;
      default: phase_nx = P_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase        <= P_IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      nbits        <= '0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      rd_frame     <= 1'b0;
      armed        <= 1'b0;
      pending      <= 1'b0;
      int1_m       <= 1'b0;
      int1_s       <= 1'b0;
      gsensor_cs_  <= 1'b1;
      gsensor_sclk <= 1'b1;
      gsensor_sdi  <= 1'b0;
      sample_valid <= 1'b0;
      x            <= '0;
      y            <= '0;
      z            <= '0;
    end else begin
      phase        <= phase_nx;
      armed        <= 1'b1;
      int1_m       <= int1;
      int1_s       <= int1_m;
      sample_valid <= 1'b0;
      div_cnt      <= (phase == P_IDLE || div_tick) ? 8'd0 : div_cnt + 8'd1;
      // one pending slot: extra triggers while it is set are dropped
      if (state == IDLE && req)          pending <= 1'b0;
      else if (trigger && state != IDLE) pending <= 1'b1;
      if (phase == P_IDLE && go) begin
        gsensor_cs_ <= 1'b0;
        bit_cnt     <= '0;
        rd_frame    <= (state == IDLE);
        nbits       <= (state == IDLE) ? RD_BITS : WR_BITS;
        tx_sr       <= (state == IDLE) ? {RD_HDR, 48'h0} : {wr_word, 40'h0};
      end
      if (shift_out) begin
        gsensor_sclk <= 1'b0;
        gsensor_sdi  <= tx_sr[55];
        tx_sr        <= {tx_sr[54:0], 1'b0};
      end
      if (phase == P_LOW && div_tick) begin
        gsensor_sclk <= 1'b1;
        rx_sr        <= {rx_sr[46:0], gsensor_sdo};
        bit_cnt      <= bit_cnt + 6'd1;
      end
      // rx_sr holds X0 X1 Y0 Y1 Z0 Z1 from MSB down; low byte arrives first
      if (phase == P_TAIL && div_tick) begin
        gsensor_cs_ <= 1'b1;
        gsensor_sdi <= 1'b0;
        if (rd_frame) begin
          x            <= {rx_sr[39:32], rx_sr[47:40]};
          y            <= {rx_sr[23:16], rx_sr[31:24]};
          z            <= {rx_sr[7:0],   rx_sr[15:8]};
          sample_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gsensor_spi.sv
// Bench for gsensor_spi: SPI slave model plus frame monitor feeding a capture queue
// that is checked against an expected-frame scoreboard.
module tb_gsensor_spi;
  localparam int CLK_DIV = 4;
  localparam int GAP     = 10;
  localparam int WR_LEN  = 16*2*CLK_DIV + 2*CLK_DIV;
  localparam int RD_LEN  = 56*2*CLK_DIV + 2*CLK_DIV;

  logic clk = 1'b0, rst = 1'b1, trigger = 1'b0, int1 = 1'b0, gsensor_sdo;
  logic gsensor_sclk, gsensor_cs_, gsensor_sdi, init_done, busy, sample_valid;
  logic [15:0] x, y, z;

  gsensor_spi #(.CLK_DIV(CLK_DIV), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .int1(int1), .gsensor_sdo(gsensor_sdo),
    .gsensor_sclk(gsensor_sclk), .gsensor_cs_(gsensor_cs_), .gsensor_sdi(gsensor_sdi),
    .init_done(init_done), .busy(busy), .x(x), .y(y), .z(z), .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int nbits; logic [55:0] mosi; int low_len, hi_len, lead, lo_min, lo_max, hi_min, hi_max;
    bit mosi_bad, sv; logic [15:0] x, y, z;
  } frame_t;
  typedef struct { int nbits; logic [55:0] mosi; bit rd; logic [15:0] x, y, z; } exp_t;

  frame_t cap_q[$];
  exp_t   exp_q[$];
  int checks = 0, failures = 0;
  int cyc = 0, sv_total = 0, cur_nb = 0;
  logic [47:0] slave_data = 48'h0;

  // monitor + slave: samples on falling clk, drives MISO after each sclk fall
  initial begin : monitor
    frame_t cur;
    bit   in_frame;
    logic pcs, psc, psdi;
    int   t_fall, t_rise, t_sc, run;
    cur = '{default: 0};
    in_frame = 0; pcs = 1; psc = 1; psdi = 0; t_fall = 0; t_rise = 0; t_sc = 0;
    gsensor_sdo = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        in_frame = 0; pcs = 1; psc = 1; psdi = 0; t_rise = cyc; cur_nb = 0; gsensor_sdo = 1'b0;
        continue;
      end
      if (sample_valid) sv_total++;
      if (pcs && !gsensor_cs_) begin
        cur = '{default: 0};
        cur.hi_len = cyc - t_rise; cur.lo_min = 1000; cur.hi_min = 1000;
        t_fall = cyc; t_sc = cyc; in_frame = 1; cur_nb = 0;
      end
      if (in_frame && !psc && gsensor_sclk) begin
        run = cyc - t_sc; t_sc = cyc;
        if (run < cur.lo_min) cur.lo_min = run;
        if (run > cur.lo_max) cur.lo_max = run;
        cur.mosi = {cur.mosi[54:0], gsensor_sdi};
        if (gsensor_sdi !== psdi) cur.mosi_bad = 1;
        cur_nb++; cur.nbits = cur_nb;
      end
      if (in_frame && psc && !gsensor_sclk) begin
        if (cur_nb == 0) cur.lead = cyc - t_fall;
        else begin
          run = cyc - t_sc;
          if (run < cur.hi_min) cur.hi_min = run;
          if (run > cur.hi_max) cur.hi_max = run;
        end
        t_sc = cyc;
        gsensor_sdo = (cur_nb >= 8 && cur_nb < 56) ? slave_data[55-cur_nb] : 1'b0;
      end
      if (in_frame && !pcs && gsensor_cs_) begin
        cur.low_len = cyc - t_fall; cur.sv = sample_valid;
        cur.x = x; cur.y = y; cur.z = z;
        cap_q.push_back(cur);
        in_frame = 0; t_rise = cyc;
      end
      pcs = gsensor_cs_; psc = gsensor_sclk; psdi = gsensor_sdi;
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic void push_wr(input logic [15:0] w);
    exp_q.push_back('{nbits: 16, mosi: 56'(w), rd: 1'b0, x: 16'h0, y: 16'h0, z: 16'h0});
  endfunction

  function automatic void push_rd(input logic [47:0] d);
    exp_q.push_back('{nbits: 56, mosi: {8'hF2, 48'h0}, rd: 1'b1,
                      x: {d[39:32], d[47:40]}, y: {d[23:16], d[31:24]}, z: {d[7:0], d[15:8]}});
  endfunction

  task automatic pulse_trigger();
    @(negedge clk); trigger = 1'b1;
    @(negedge clk); trigger = 1'b0;
  endtask

  task automatic wait_caps(input int n, input int budget, output bit ok);
    int c = 0;
    while (cap_q.size() < n && c < budget) begin @(negedge clk); c++; end
    ok = (cap_q.size() >= n);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (gsensor_cs_ !== 1'b1 || gsensor_sclk !== 1'b1 || gsensor_sdi !== 1'b0) begin
      failures++; $display("FAIL reset_spi got cs=%b sclk=%b sdi=%b exp=1 1 0", gsensor_cs_, gsensor_sclk, gsensor_sdi); end
    checks++; if (init_done !== 1'b0 || busy !== 1'b0 || sample_valid !== 1'b0) begin
      failures++; $display("FAIL reset_status got done=%b busy=%b sv=%b exp=0 0 0", init_done, busy, sample_valid); end
    checks++; if ({x, y, z} !== 48'h0) begin
      failures++; $display("FAIL reset_xyz got=%h exp=0", {x, y, z}); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (gsensor_cs_ !== 1'b1) begin failures++; $display("FAIL cs_edge1 got=%b exp=1", gsensor_cs_); end
    @(posedge clk); #1;
    checks++; if (gsensor_cs_ !== 1'b0) begin failures++; $display("FAIL cs_edge2 got=%b exp=0", gsensor_cs_); end
  endtask

  task automatic test_init();
    logic [15:0] words[4];
    int since = 1000, busy_bad = 0;
    logic pc;
    bit ok;
    frame_t f; exp_t e;
    words = '{16'h310B, 16'h2F00, 16'h2E80, 16'h2D08};
    foreach (words[i]) push_wr(words[i]);
    slave_data = 48'h0102_0304_0506;
    push_rd(slave_data);
    pulse_trigger();
    pc = gsensor_cs_;
    for (int c = 0; c < 3000 && !init_done; c++) begin
      @(negedge clk);
      if (!init_done && !busy) busy_bad++;
      if (gsensor_cs_ && !pc) since = 0; else since++;
      pc = gsensor_cs_;
    end
    checks++; if (init_done !== 1'b1) begin failures++; $display("FAIL init_done got=%b exp=1", init_done); end
    checks++; if (busy_bad != 0) begin failures++; $display("FAIL init_busy got=%0d_drops exp=0", busy_bad); end
    checks++; if (since != GAP) begin failures++; $display("FAIL init_done_time got=%0d exp=%0d", since, GAP); end
    wait_caps(5, 2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL init_frames got=%0d exp=5", cap_q.size()); cap_q.delete(); exp_q.delete(); return; end
    for (int i = 0; i < 5; i++) begin
      f = cap_q.pop_front(); e = exp_q.pop_front();
      checks++; if (f.nbits != e.nbits || f.mosi !== e.mosi) begin
        failures++; $display("FAIL init_mosi%0d got=%0d/%h exp=%0d/%h", i, f.nbits, f.mosi, e.nbits, e.mosi); end
      checks++; if (f.low_len != (e.rd ? RD_LEN : WR_LEN)) begin
        failures++; $display("FAIL init_len%0d got=%0d exp=%0d", i, f.low_len, e.rd ? RD_LEN : WR_LEN); end
      if (i > 0 && i < 4) begin
        checks++; if (f.hi_len < GAP) begin failures++; $display("FAIL init_gap%0d got=%0d exp>=%0d", i, f.hi_len, GAP); end
      end
    end
    checks++; if (f.hi_len != GAP + 1) begin failures++; $display("FAIL pend_after_init got=%0d exp=%0d", f.hi_len, GAP + 1); end
    checks++; if (f.sv !== 1'b1 || {f.x, f.y, f.z} !== {e.x, e.y, e.z}) begin
      failures++; $display("FAIL init_read got sv=%b %h exp sv=1 %h", f.sv, {f.x, f.y, f.z}, {e.x, e.y, e.z}); end
  endtask

  task automatic test_read();
    bit ok; int sv0;
    frame_t f; exp_t e;
    repeat (5) @(negedge clk);
    slave_data = 48'h3412_FFFF_0080;
    push_rd(slave_data);
    sv0 = sv_total;
    pulse_trigger();
    wait_caps(1, 2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL read_done got=0 exp=1"); exp_q.delete(); return; end
    f = cap_q.pop_front(); e = exp_q.pop_front();
    checks++; if (f.nbits != 56 || f.mosi !== {8'hF2, 48'h0}) begin
      failures++; $display("FAIL read_mosi got=%0d/%h exp=56/f2000000000000", f.nbits, f.mosi); end
    checks++; if (f.x !== 16'h1234 || f.y !== 16'hFFFF || f.z !== 16'h8000) begin
      failures++; $display("FAIL read_xyz got=%h %h %h exp=1234 ffff 8000", f.x, f.y, f.z); end
    checks++; if ({f.x, f.y, f.z} !== {e.x, e.y, e.z}) begin
      failures++; $display("FAIL read_model got=%h exp=%h", {f.x, f.y, f.z}, {e.x, e.y, e.z}); end
    checks++; if (f.sv !== 1'b1) begin failures++; $display("FAIL read_sv_at_rise got=%b exp=1", f.sv); end
    checks++; if (f.low_len != RD_LEN) begin failures++; $display("FAIL read_len got=%0d exp=%0d", f.low_len, RD_LEN); end
    checks++; if (f.lead != CLK_DIV) begin failures++; $display("FAIL read_lead got=%0d exp=%0d", f.lead, CLK_DIV); end
    checks++; if (f.lo_min != CLK_DIV || f.lo_max != CLK_DIV || f.hi_min != CLK_DIV || f.hi_max != CLK_DIV) begin
      failures++; $display("FAIL read_sclk got lo=%0d..%0d hi=%0d..%0d exp=%0d", f.lo_min, f.lo_max, f.hi_min, f.hi_max, CLK_DIV); end
    checks++; if (f.mosi_bad) begin failures++; $display("FAIL read_mosi_stable got=changed exp=stable"); end
    repeat (30) @(negedge clk);
    checks++; if (sv_total - sv0 != 1) begin failures++; $display("FAIL read_sv_count got=%0d exp=1", sv_total - sv0); end
    checks++; if (x !== 16'h1234 || y !== 16'hFFFF || z !== 16'h8000) begin
      failures++; $display("FAIL read_hold got=%h %h %h exp=1234 ffff 8000", x, y, z); end
  endtask

  task automatic test_pending();
    bit ok; int c = 0;
    frame_t f; exp_t e;
    slave_data = {16'($urandom), 32'($urandom)};
    push_rd(slave_data); push_rd(slave_data);
    pulse_trigger();
    while (gsensor_cs_ && c < 20) begin @(negedge clk); c++; end
    repeat (50) @(negedge clk);
    pulse_trigger();
    repeat (30) @(negedge clk);
    pulse_trigger();
    wait_caps(2, 3000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL pend_frames got=%0d exp=2", cap_q.size()); cap_q.delete(); exp_q.delete(); return; end
    for (int i = 0; i < 2; i++) begin
      f = cap_q.pop_front(); e = exp_q.pop_front();
      checks++; if (f.mosi !== e.mosi || f.sv !== 1'b1 || {f.x, f.y, f.z} !== {e.x, e.y, e.z}) begin
        failures++; $display("FAIL pend_read%0d got sv=%b %h exp sv=1 %h", i, f.sv, {f.x, f.y, f.z}, {e.x, e.y, e.z}); end
    end
    checks++; if (f.hi_len != GAP + 1) begin failures++; $display("FAIL pend_gap got=%0d exp=%0d", f.hi_len, GAP + 1); end
    repeat (600) @(negedge clk);
    checks++; if (cap_q.size() != 0 || busy !== 1'b0) begin
      failures++; $display("FAIL pend_extra got frames=%0d busy=%b exp=0 0", cap_q.size(), busy); end
  endtask

  task automatic test_back_to_back();
    bit ok; int sv0;
    frame_t f; exp_t e;
    slave_data = {16'($urandom), 32'($urandom)};
    repeat (3) push_rd(slave_data);
    sv0 = sv_total;
    @(negedge clk); int1 = 1'b1;
    wait_caps(3, 3000, ok);
    int1 = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL b2b_frames got=%0d exp=3", cap_q.size()); cap_q.delete(); exp_q.delete(); return; end
    for (int i = 0; i < 3; i++) begin
      f = cap_q.pop_front(); e = exp_q.pop_front();
      checks++; if (f.sv !== 1'b1 || {f.x, f.y, f.z} !== {e.x, e.y, e.z}) begin
        failures++; $display("FAIL b2b_read%0d got sv=%b %h exp sv=1 %h", i, f.sv, {f.x, f.y, f.z}, {e.x, e.y, e.z}); end
      checks++; if (f.hi_len < GAP) begin failures++; $display("FAIL b2b_gap%0d got=%0d exp>=%0d", i, f.hi_len, GAP); end
    end
    repeat (600) @(negedge clk);
    checks++; if (cap_q.size() != 0 || sv_total - sv0 != 3) begin
      failures++; $display("FAIL b2b_count got frames=%0d sv=%0d exp=0 3", cap_q.size(), sv_total - sv0); end
  endtask

  task automatic test_reset_mid();
    bit ok; int c = 0, sv0;
    logic [15:0] words[4];
    frame_t f; exp_t e;
    slave_data = {16'($urandom), 32'($urandom)};
    pulse_trigger();
    while (cur_nb < 20 && c < 1000) begin @(negedge clk); c++; end
    checks++; if (cur_nb < 20) begin failures++; $display("FAIL mid_reach got=%0d exp=20", cur_nb); end
    sv0 = sv_total;
    rst = 1'b1; #1;
    checks++; if (gsensor_cs_ !== 1'b1 || gsensor_sclk !== 1'b1) begin
      failures++; $display("FAIL mid_async got cs=%b sclk=%b exp=1 1", gsensor_cs_, gsensor_sclk); end
    repeat (3) @(negedge clk);
    checks++; if ({x, y, z} !== 48'h0 || sample_valid !== 1'b0 || sv_total != sv0 || cap_q.size() != 0) begin
      failures++; $display("FAIL mid_abort got xyz=%h sv=%0d frames=%0d exp=0 0 0", {x, y, z}, sv_total - sv0, cap_q.size()); end
    rst = 1'b0;
    words = '{16'h310B, 16'h2F00, 16'h2E80, 16'h2D08};
    foreach (words[i]) push_wr(words[i]);
    wait_caps(4, 2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL mid_reinit got=%0d exp=4", cap_q.size()); cap_q.delete(); exp_q.delete(); return; end
    for (int i = 0; i < 4; i++) begin
      f = cap_q.pop_front(); e = exp_q.pop_front();
      checks++; if (f.nbits != 16 || f.mosi !== e.mosi) begin
        failures++; $display("FAIL mid_mosi%0d got=%0d/%h exp=16/%h", i, f.nbits, f.mosi, e.mosi); end
    end
    c = 0;
    while (!init_done && c < 100) begin @(negedge clk); c++; end
    checks++; if (init_done !== 1'b1) begin failures++; $display("FAIL mid_done got=%b exp=1", init_done); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_read();
    test_pending();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
